// File: rtl/reduce_pkg.sv
// Shared defaults and state encoding for the batch scheduler in front of reduce_sum.
package reduce_pkg;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BATCH_LEN_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    RESP
  } sched_state_t;
endpackage

// File: rtl/reduce_batch_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_id
);
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_sel;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_sum   = '0;
    w_sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // wrap ptr+i without a general modulo
      w_sum = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NUM_REQ))
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      w_sel = w_sum[IDW-1:0];
      if ((o_grant == '0) && i_req[w_sel]) begin
        o_grant[w_sel] = 1'b1;
        o_id           = w_sel;
      end
    end
  end
endmodule

// File: rtl/reduce_batch_scheduler.sv
// Time-shares one reduce_sum engine between requesters, one locked batch at a time.
module reduce_batch_scheduler
  import reduce_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BATCH_LEN      = BATCH_LEN_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned RESULT_TIMEOUT = 100,
  localparam int unsigned IDW           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         eng_in_data,
  output logic                      eng_in_valid,
  input  logic [DATA_W-1:0]         eng_out_data,
  input  logic                      eng_out_valid,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);
  localparam int unsigned WCW = $clog2(BATCH_LEN + 1);
  localparam int unsigned TCW = $clog2(RESULT_TIMEOUT + 1);

  sched_state_t      r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_grant_id;
  logic [WCW-1:0]    r_wcnt;
  logic [TCW-1:0]    r_tcnt;
  logic              r_eng_in_valid;
  logic [DATA_W-1:0] r_eng_in_data;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDW-1:0]     w_arb_id;
  logic               w_accept;
  logic [DATA_W-1:0]  w_word;
  logic [IDW-1:0]     w_ptr_next;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_id    (w_arb_id)
  );

  assign w_accept   = (r_state == STREAM) && req_valid[r_grant_id];
  assign w_word     = req_data[r_grant_id*DATA_W +: DATA_W];
  assign w_ptr_next = (w_arb_id == IDW'(NUM_REQ-1)) ? '0 : w_arb_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (r_state == STREAM)
      req_ready[r_grant_id] = req_valid[r_grant_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_grant_id     <= '0;
      r_wcnt         <= '0;
      r_tcnt         <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_in_data  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_eng_in_valid <= 1'b0;
      r_rsp_valid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arb_grant != '0) begin
            r_grant_id <= w_arb_id;
            r_ptr      <= w_ptr_next;
            r_wcnt     <= '0;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (w_accept) begin
            r_eng_in_valid <= 1'b1;
            r_eng_in_data  <= w_word;
            if (r_wcnt == WCW'(BATCH_LEN-1)) begin
              r_wcnt  <= '0;
              r_tcnt  <= '0;
              r_state <= WAIT_RES;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          // a result arriving on the final timeout cycle still wins
          if (eng_out_valid) begin
            r_rsp_data  <= eng_out_data;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_grant_id;
            r_state     <= RESP;
          end else if (r_tcnt == TCW'(RESULT_TIMEOUT-1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_grant_id;
            r_state     <= RESP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign eng_in_valid = r_eng_in_valid;
  assign eng_in_data  = r_eng_in_data;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign busy         = (r_state != IDLE);
endmodule

// File: tb/tb_reduce_batch_scheduler.sv
// Bench for reduce_batch_scheduler: engine stand-in, cycle model, directed scenarios.
module tb_reduce_batch_scheduler;
  localparam int NR = 4, BL = 1024, DW = 32, TO = 100, LAT = 3, IW = 2;
  localparam int P_IDLE = 0, P_STREAM = 1, P_WAIT = 2, P_RESP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    eng_in_data;
  logic             eng_in_valid;
  logic [DW-1:0]    eng_out_data;
  logic             eng_out_valid;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             rsp_err;
  logic             busy;

  always #5 clk = ~clk;

  reduce_batch_scheduler #(.NUM_REQ(NR), .BATCH_LEN(BL), .DATA_W(DW), .RESULT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_in_data(eng_in_data), .eng_in_valid(eng_in_valid),
    .eng_out_data(eng_out_data), .eng_out_valid(eng_out_valid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Engine stand-in: sums each batch, answers LAT cycles later when enabled.
  bit          eng_en = 1'b1;
  logic        eng_auto_v = 1'b0, inj_v = 1'b0;
  logic [31:0] eng_auto_d = '0, eng_acc = '0, eng_done = '0, inj_d = '0;
  int          eng_cnt = 0, eng_pend = 0;
  assign eng_out_valid = eng_auto_v | inj_v;
  assign eng_out_data  = inj_v ? inj_d : eng_auto_d;

  always @(posedge clk) begin
    if (rst) begin
      eng_auto_v <= 1'b0; eng_acc <= '0; eng_cnt <= 0; eng_pend <= 0;
    end else begin
      eng_auto_v <= 1'b0;
      if (eng_pend != 0) begin
        eng_pend <= eng_pend - 1;
        if (eng_pend == 1) begin eng_auto_v <= 1'b1; eng_auto_d <= eng_done; end
      end
      if (eng_in_valid) begin
        if (eng_cnt == BL-1) begin
          eng_done <= eng_acc + eng_in_data; eng_acc <= '0; eng_cnt <= 0;
          if (eng_en) eng_pend <= LAT;
        end else begin
          eng_acc <= eng_acc + eng_in_data; eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  // Cycle model of the scheduler written from the batch rules.
  function automatic int rr_pick(input logic [NR-1:0] v, input logic [IW-1:0] p);
    for (int j = 0; j < NR; j++) begin
      logic [IW-1:0] ix;
      ix = IW'((int'(p) + j) % NR);
      if (v[ix]) return int'(ix);
    end
    return -1;
  endfunction

  bit            m_valid = 1'b0;
  int            m_phase = P_IDLE, m_left = 0, m_wait = 0;
  logic [IW-1:0] m_ptr = '0, m_owner = '0;
  logic          e_eng_v = 1'b0, e_rsp_v = 1'b0, e_err = 1'b0;
  logic [DW-1:0] e_eng_d = '0, e_rd = '0;
  logic [IW-1:0] e_id = '0;
  logic [NR-1:0] e_ready;
  assign e_ready = (m_phase == P_STREAM) ? (req_valid & (NR'(1) << m_owner)) : '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1; m_phase <= P_IDLE; m_ptr <= '0; m_owner <= '0; m_left <= 0; m_wait <= 0;
      e_eng_v <= 1'b0; e_eng_d <= '0; e_rsp_v <= 1'b0; e_id <= '0; e_rd <= '0; e_err <= 1'b0;
    end else if (m_valid) begin
      e_eng_v <= 1'b0;
      e_rsp_v <= 1'b0;
      case (m_phase)
        P_IDLE: if (rr_pick(req_valid, m_ptr) >= 0) begin
          m_owner <= IW'(rr_pick(req_valid, m_ptr));
          m_ptr   <= IW'((rr_pick(req_valid, m_ptr) + 1) % NR);
          m_left  <= BL;
          m_phase <= P_STREAM;
        end
        P_STREAM: if (req_valid[m_owner]) begin
          e_eng_v <= 1'b1;
          e_eng_d <= req_data[m_owner*DW +: DW];
          m_left  <= m_left - 1;
          if (m_left == 1) begin m_phase <= P_WAIT; m_wait <= 0; end
        end
        P_WAIT: begin
          if (eng_out_valid) begin
            e_rsp_v <= 1'b1; e_id <= m_owner; e_rd <= eng_out_data; e_err <= 1'b0; m_phase <= P_RESP;
          end else if (m_wait + 1 == TO) begin
            e_rsp_v <= 1'b1; e_id <= m_owner; e_rd <= '0; e_err <= 1'b1; m_phase <= P_RESP;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  int in_pulses = 0, last_in_cyc = 0, rsp_seen = 0, multi = 0;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("eng_in_valid", 64'(eng_in_valid), 64'(e_eng_v));
      chk("eng_in_data", 64'(eng_in_data), 64'(e_eng_d));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_v));
      chk("rsp_id", 64'(rsp_id), 64'(e_id));
      chk("rsp_data", 64'(rsp_data), 64'(e_rd));
      chk("rsp_err", 64'(rsp_err), 64'(e_err));
      chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
    end
    if (eng_in_valid) begin in_pulses <= in_pulses + 1; last_in_cyc <= cyc; end
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
    if ($countones(req_ready) > 1) multi <= multi + 1;
  end

  // Streams n words (value (start+i)%256 + add) from requester k; alt toggles valid each cycle.
  task automatic send(input int k, input int n, input bit alt, input int start,
                      input logic [31:0] add, output logic [31:0] sum);
    logic [IW-1:0] kk;
    int i, c;
    bit ph, acc;
    logic [31:0] w;
    kk = IW'(k); i = 0; c = 0; ph = 1'b1; sum = '0;
    while (i < n && c < 5000) begin
      w = 32'((start + i) % 256) + add;
      req_data[k*DW +: DW] = w;
      req_valid[kk] = alt ? ph : 1'b1;
      @(negedge clk);
      acc = req_valid[kk] && req_ready[kk];
      tick();
      if (acc) begin i++; sum = sum + w; end
      ph = ~ph;
      c++;
    end
    req_valid[kk] = 1'b0;
    chk("send_words", 64'(i), 64'(n));
  endtask

  task automatic wait_rsp(output int id, output logic [31:0] d, output logic e, output int lat);
    bit ok;
    ok = 1'b0; id = -1; d = 'x; e = 'x; lat = -1;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; id = int'(rsp_id); d = rsp_data; e = rsp_err; lat = cyc - last_in_cyc; end
      tick();
    end
    chk("rsp_arrived", 64'(ok), 64'd1);
  endtask

  logic [31:0] sum, s1, s2, d;
  logic        e;
  int          id, lat, base, rs, got;
  int          ids[5];
  logic [31:0] dats[5];

  initial begin
    // Reset state, with all requests pending to prove none are accepted in reset/IDLE
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_in_valid", 64'(eng_in_valid), 64'd0);
    chk("rst_eng_in_data", 64'(eng_in_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0; req_valid = '0;
    tick();

    // 1: requester 1 alone, back-to-back i%256
    base = in_pulses;
    send(1, BL, 1'b0, 0, 32'h0, sum);
    wait_rsp(id, d, e, lat);
    chk("t1_sum_pin", 64'(sum), 64'h0001FE00);
    chk("t1_pulses", 64'(in_pulses - base), 64'(BL));
    chk("t1_id", 64'(id), 64'd1);
    chk("t1_data", 64'(d), 64'h0001FE00);
    chk("t1_err", 64'(e), 64'd0);

    // 2: all requesters continuously from reset
    for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = 32'(k + 1);
    req_valid = '1; rst = 1'b1; tick(); tick(); rst = 1'b0;
    multi = 0; got = 0;
    for (int k = 0; k < 5; k++) begin ids[k] = -1; dats[k] = '0; end
    for (int c = 0; c < 7000 && got < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin ids[got] = int'(rsp_id); dats[got] = rsp_data; got++; end
      tick();
    end
    req_valid = '0;
    chk("t2_rsp_count", 64'(got), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", 64'(ids[k]), 64'(k % NR));
      chk("t2_data", 64'(dats[k]), 64'(BL * ((k % NR) + 1)));
    end
    chk("t2_onehot", 64'(multi), 64'd0);
    tick();

    // 3: requester 2 valid every other cycle
    base = in_pulses;
    send(2, BL, 1'b1, 0, 32'h100, sum);
    wait_rsp(id, d, e, lat);
    chk("t3_sum_pin", 64'(sum), 64'h0005FE00);
    chk("t3_pulses", 64'(in_pulses - base), 64'(BL));
    chk("t3_id", 64'(id), 64'd2);
    chk("t3_data", 64'(d), 64'(sum));
    chk("t3_err", 64'(e), 64'd0);

    // 4: silent engine -> timeout, then a normal batch
    eng_en = 1'b0;
    send(0, BL, 1'b0, 0, 32'h0, sum);
    wait_rsp(id, d, e, lat);
    chk("t4_latency", 64'(lat), 64'(TO));
    chk("t4_err", 64'(e), 64'd1);
    chk("t4_data", 64'(d), 64'd0);
    chk("t4_id", 64'(id), 64'd0);
    eng_en = 1'b1;
    send(3, BL, 1'b0, 5, 32'h7, sum);
    wait_rsp(id, d, e, lat);
    chk("t4b_id", 64'(id), 64'd3);
    chk("t4b_data", 64'(d), 64'(sum));
    chk("t4b_err", 64'(e), 64'd0);

    // 5: reset after word 500, with the next word pending
    send(1, 500, 1'b0, 0, 32'h0, sum);
    req_valid[1] = 1'b1; rst = 1'b1;
    tick();
    chk("t5_eng_in_valid", 64'(eng_in_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0; req_valid = '0;
    rs = rsp_seen;
    repeat (150) tick();
    chk("t5_no_rsp", 64'(rsp_seen - rs), 64'd0);
    base = in_pulses;
    send(1, BL, 1'b0, 3, 32'h55, sum);
    wait_rsp(id, d, e, lat);
    chk("t5_pulses", 64'(in_pulses - base), 64'(BL));
    chk("t5_id", 64'(id), 64'd1);
    chk("t5_data", 64'(d), 64'(sum));

    // 6: stray result during STREAM, then result on the final timeout cycle
    eng_en = 1'b0;
    rs = rsp_seen;
    send(0, 300, 1'b0, 0, 32'h11, s1);
    inj_v = 1'b1; inj_d = 32'hDEADBEEF;
    tick();
    inj_v = 1'b0;
    send(0, BL - 300, 1'b0, 300, 32'h11, s2);
    sum = s1 + s2;
    repeat (TO - 1) tick();
    inj_v = 1'b1; inj_d = sum;
    tick();
    inj_v = 1'b0;
    wait_rsp(id, d, e, lat);
    chk("t6_one_rsp", 64'(rsp_seen - rs), 64'd1);
    chk("t6_latency", 64'(lat), 64'(TO));
    chk("t6_err", 64'(e), 64'd0);
    chk("t6_data", 64'(d), 64'(sum));
    chk("t6_id", 64'(id), 64'd0);
    eng_en = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
